// File: rtl/gnrl_pkg.sv
// Shared definitions for the gnrl_* blocks: default widths and the delay-meter
// one-hot state encoding.
package gnrl_pkg;

    localparam int GNRL_DELAY_WIDTH = 32;

    localparam logic [2:0] GNRL_DM_IDLE     = 3'b001;
    localparam logic [2:0] GNRL_DM_COUNT    = 3'b010;
    localparam logic [2:0] GNRL_DM_WAIT_LOW = 3'b100;

    typedef enum logic [2:0] {
        DM_IDLE     = GNRL_DM_IDLE,
        DM_COUNT    = GNRL_DM_COUNT,
        DM_WAIT_LOW = GNRL_DM_WAIT_LOW
    } gnrl_dm_state_e;

endpackage

// File: rtl/gnrl_edge_det.sv
// One-bit rising-edge detector. The previous-sample register resets to
// RESET_VAL so a level already high at reset release is not seen as an edge.
module gnrl_edge_det #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic D,
    output logic RISE
);

    logic prev;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prev <= RESET_VAL;
        end else begin
            prev <= D;
        end
    end

    assign RISE = D & ~prev;

endmodule

// File: rtl/gnrl_pulse_delay_meter.sv
// Measures CLK cycles from a START_IN rising edge to the next STOP_IN rising
// edge, with optional timeout and counter saturation; one result per activation.
module gnrl_pulse_delay_meter
    import gnrl_pkg::*;
#(
    parameter int DELAY_WIDTH = GNRL_DELAY_WIDTH
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   START_IN,
    input  logic                   STOP_IN,
    input  logic [DELAY_WIDTH-1:0] TIMEOUT,
    output logic [DELAY_WIDTH-1:0] DELAY_OUT,
    output logic                   TIMED_OUT,
    output logic                   DELAY_VALID,
    output logic                   BUSY
);

    gnrl_dm_state_e         state;
    logic [DELAY_WIDTH-1:0] cnt;
    logic [DELAY_WIDTH-1:0] to_reg;
    logic                   start_rise;
    logic                   stop_rise;

    gnrl_edge_det #(.RESET_VAL(1'b1)) u_start_det (
        .CLK   (CLK),
        .RESET (RESET),
        .D     (START_IN),
        .RISE  (start_rise)
    );

    gnrl_edge_det #(.RESET_VAL(1'b1)) u_stop_det (
        .CLK   (CLK),
        .RESET (RESET),
        .D     (STOP_IN),
        .RISE  (stop_rise)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= DM_IDLE;
            cnt         <= '0;
            to_reg      <= '0;
            DELAY_OUT   <= '0;
            TIMED_OUT   <= 1'b0;
            DELAY_VALID <= 1'b0;
        end else begin
            case (state)
                DM_IDLE: begin
                    DELAY_VALID <= 1'b0;
                    // A stop edge coinciding with the start edge is deliberately ignored.
                    if (start_rise) begin
                        cnt    <= DELAY_WIDTH'(1);
                        to_reg <= TIMEOUT;
                        state  <= DM_COUNT;
                    end
                end
                DM_COUNT: begin
                    // Stop wins over timeout and saturation when they coincide.
                    if (stop_rise) begin
                        DELAY_OUT   <= cnt;
                        TIMED_OUT   <= 1'b0;
                        DELAY_VALID <= 1'b1;
                        state       <= DM_WAIT_LOW;
                    end else if ((to_reg != '0) && (cnt == to_reg)) begin
                        DELAY_OUT   <= to_reg;
                        TIMED_OUT   <= 1'b1;
                        DELAY_VALID <= 1'b1;
                        state       <= DM_WAIT_LOW;
                    end else if (cnt == '1) begin
                        DELAY_OUT   <= '1;
                        TIMED_OUT   <= 1'b1;
                        DELAY_VALID <= 1'b1;
                        state       <= DM_WAIT_LOW;
                    end else begin
                        cnt <= cnt + DELAY_WIDTH'(1);
                    end
                end
                DM_WAIT_LOW: begin
                    DELAY_VALID <= 1'b0;
                    if (!START_IN) begin
                        state <= DM_IDLE;
                    end
                end
                default: begin
                    state       <= DM_IDLE;
                    DELAY_VALID <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY = (state != DM_IDLE);

endmodule

// File: tb/tb_gnrl_pulse_delay_meter.sv
// Directed bench for gnrl_pulse_delay_meter: a 32-bit and a 4-bit instance,
// checked every cycle against an elapsed-time model plus literal expectations.
module tb_gnrl_pulse_delay_meter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start_a, stop_a, start_b, stop_b;
    logic [31:0] to_a;
    logic [3:0]  to_b;
    logic [31:0] delay_a;
    logic [3:0]  delay_b;
    logic        timed_a, valid_a, busy_a;
    logic        timed_b, valid_b, busy_b;

    int checks   = 0;
    int failures = 0;
    int strobes_a = 0;
    int strobes_b = 0;
    bit cmp_en   = 1'b0;

    always #5 CLK = ~CLK;

    gnrl_pulse_delay_meter #(.DELAY_WIDTH(32)) dut_a (
        .CLK(CLK), .RESET(RESET), .START_IN(start_a), .STOP_IN(stop_a),
        .TIMEOUT(to_a), .DELAY_OUT(delay_a), .TIMED_OUT(timed_a),
        .DELAY_VALID(valid_a), .BUSY(busy_a)
    );

    gnrl_pulse_delay_meter #(.DELAY_WIDTH(4)) dut_b (
        .CLK(CLK), .RESET(RESET), .START_IN(start_b), .STOP_IN(stop_b),
        .TIMEOUT(to_b), .DELAY_OUT(delay_b), .TIMED_OUT(timed_b),
        .DELAY_VALID(valid_b), .BUSY(busy_b)
    );

    // Model: elapsed cycles since the arming edge, compared against stop/timeout/limit.
    longint cyc = 0;
    int     m_phase [2];  // 0 idle, 1 measuring, 2 waiting for start low
    longint m_t0    [2];
    longint m_to    [2];
    longint m_delay [2];
    logic   m_timed [2];
    logic   m_valid [2];
    logic   m_ps    [2];
    logic   m_pp    [2];

    task automatic report(input int i, input longint d, input logic t);
        m_delay[i] = d;
        m_timed[i] = t;
        m_valid[i] = 1'b1;
        m_phase[i] = 2;
    endtask

    task automatic model_step(input int i, input logic s, input logic p,
                              input longint to, input longint limit);
        logic   s_edge, p_edge;
        longint k;
        s_edge  = s && !m_ps[i];
        p_edge  = p && !m_pp[i];
        m_ps[i] = s;
        m_pp[i] = p;
        m_valid[i] = 1'b0;
        k = cyc - m_t0[i];
        if (m_phase[i] == 0) begin
            if (s_edge) begin
                m_t0[i]    = cyc;
                m_to[i]    = to;
                m_phase[i] = 1;
            end
        end else if (m_phase[i] == 1) begin
            if (p_edge)                          report(i, k, 1'b0);
            else if (m_to[i] != 0 && k == m_to[i]) report(i, m_to[i], 1'b1);
            else if (k == limit)                 report(i, limit, 1'b1);
        end else begin
            if (!s) m_phase[i] = 0;
        end
    endtask

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] = 0;
                m_t0[i]    = 0;
                m_to[i]    = 0;
                m_delay[i] = 0;
                m_timed[i] = 1'b0;
                m_valid[i] = 1'b0;
                m_ps[i]    = 1'b1;
                m_pp[i]    = 1'b1;
            end
        end else begin
            cyc = cyc + 1;
            model_step(0, start_a, stop_a, longint'(to_a), 64'hFFFF_FFFF);
            model_step(1, start_b, stop_b, longint'(to_b), 15);
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("a_delay", longint'(delay_a), m_delay[0]);
            check("a_timed", longint'(timed_a), longint'(m_timed[0]));
            check("a_valid", longint'(valid_a), longint'(m_valid[0]));
            check("a_busy",  longint'(busy_a),  longint'(m_phase[0] != 0));
            check("b_delay", longint'(delay_b), m_delay[1]);
            check("b_timed", longint'(timed_b), longint'(m_timed[1]));
            check("b_valid", longint'(valid_b), longint'(m_valid[1]));
            check("b_busy",  longint'(busy_b),  longint'(m_phase[1] != 0));
            if (valid_a === 1'b1) strobes_a = strobes_a + 1;
            if (valid_b === 1'b1) strobes_b = strobes_b + 1;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Start edge sampled at posedge t0, stop edge sampled at t0 + k.
    task automatic measure_a(input int k);
        start_a = 1'b1;
        cycles(k);
        stop_a = 1'b1;
        cycles(2);
        start_a = 1'b0;
        stop_a  = 1'b0;
        cycles(3);
    endtask

    task automatic expect_a(input string name, input longint d, input longint t,
                            input int n_strobes, input int base);
        check({name, "_delay"},   longint'(delay_a), d);
        check({name, "_timed"},   longint'(timed_a), t);
        check({name, "_strobes"}, longint'(strobes_a - base), longint'(n_strobes));
    endtask

    int base;

    initial begin
        RESET   = 1'b1;
        start_a = 1'b0; stop_a = 1'b0; to_a = 32'd0;
        start_b = 1'b0; stop_b = 1'b0; to_b = 4'd0;
        cycles(3);
        RESET  = 1'b0;
        cmp_en = 1'b1;
        cycles(2);
        check("reset_delay", longint'(delay_a), 0);
        check("reset_busy",  longint'(busy_a), 0);
        check("reset_valid", longint'(valid_a), 0);

        // Basic measurement
        base = strobes_a;
        measure_a(15);
        expect_a("basic", 15, 0, 1, base);

        // Back-to-back edges
        base = strobes_a;
        measure_a(1);
        expect_a("min", 1, 0, 1, base);

        // Stop edge in the arming cycle is ignored
        base = strobes_a;
        start_a = 1'b1; stop_a = 1'b1;
        cycles(3);
        stop_a = 1'b0;
        cycles(2);
        check("same_busy",    longint'(busy_a), 1);
        check("same_strobes", longint'(strobes_a - base), 0);
        stop_a = 1'b1;
        cycles(2);
        start_a = 1'b0; stop_a = 1'b0;
        cycles(3);
        expect_a("late_stop", 5, 0, 1, base);

        // Timeout with no stop
        base = strobes_a;
        to_a = 32'd100;
        start_a = 1'b1;
        cycles(103);
        start_a = 1'b0;
        cycles(3);
        expect_a("timeout", 100, 1, 1, base);

        // Stop coinciding with timeout wins
        base = strobes_a;
        measure_a(100);
        expect_a("stop_at_to", 100, 0, 1, base);
        to_a = 32'd0;

        // Held start, two stop pulses, single result
        base = strobes_a;
        start_a = 1'b1;
        cycles(20); stop_a = 1'b1;
        cycles(1);  stop_a = 1'b0;
        cycles(19); stop_a = 1'b1;
        cycles(1);  stop_a = 1'b0;
        cycles(459);
        check("held_busy", longint'(busy_a), 1);
        start_a = 1'b0;
        cycles(3);
        expect_a("held", 20, 0, 1, base);
        base = strobes_a;
        measure_a(33);
        expect_a("rearm", 33, 0, 1, base);

        // Reset mid-count, start held across release
        base = strobes_a;
        start_a = 1'b1;
        cycles(7);
        #1 RESET = 1'b1;
        cycles(2);
        check("rst_mid_delay", longint'(delay_a), 0);
        check("rst_mid_busy",  longint'(busy_a), 0);
        RESET = 1'b0;
        cycles(10);
        check("rst_held_busy",    longint'(busy_a), 0);
        check("rst_held_strobes", longint'(strobes_a - base), 0);
        start_a = 1'b0;
        cycles(1);
        measure_a(9);
        expect_a("after_rst", 9, 0, 1, base);

        // Saturation on the 4-bit instance
        base = strobes_b;
        start_b = 1'b1;
        cycles(20);
        start_b = 1'b0;
        cycles(3);
        check("sat_delay",   longint'(delay_b), 15);
        check("sat_timed",   longint'(timed_b), 1);
        check("sat_strobes", longint'(strobes_b - base), 1);

        cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
